// File: rtl/cpu_types_pkg.sv
// Shared CPU types and default sizes for the multi-port register file.
package cpu_types_pkg;

    localparam int DEFAULT_DWIDTH = 32;
    localparam int DEFAULT_DEPTH  = 32;

    typedef logic [DEFAULT_DWIDTH-1:0] word_t;
    typedef logic [DEFAULT_DEPTH-1:0]  regbits_t;

endpackage

// File: rtl/register_file_mp_if.sv
// Bundle of every register_file_mp signal, with a design-side and a bench-side view.
interface register_file_mp_if
    import cpu_types_pkg::*;
#(
    parameter int DWIDTH = DEFAULT_DWIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    localparam int AW    = $clog2(DEPTH)
) ();

    logic                          CLK;
    logic                          RST;
    logic [NWRITE-1:0]             wen;
    logic [NWRITE-1:0][AW-1:0]     wsel;
    logic [NWRITE-1:0][DWIDTH-1:0] wdat;
    logic [NREAD-1:0][AW-1:0]      rsel;
    logic [NREAD-1:0][DWIDTH-1:0]  rdat;
    logic                          claim_en;
    logic [AW-1:0]                 claim_sel;
    logic [DEPTH-1:0]              busy;
    logic [NREAD-1:0]              rbusy;

    modport rf (
        input  CLK, RST, wen, wsel, wdat, rsel, claim_en, claim_sel,
        output rdat, busy, rbusy
    );

    modport tb (
        output CLK, RST, wen, wsel, wdat, rsel, claim_en, claim_sel,
        input  rdat, busy, rbusy
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-producer flags: a claim marks a register busy, a write clears it.
module rf_scoreboard #(
    parameter int DEPTH  = 32,
    parameter int NWRITE = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NWRITE-1:0]         wen,
    input  logic [NWRITE-1:0][AW-1:0] wsel,
    input  logic                      claim_en,
    input  logic [AW-1:0]             claim_sel,
    output logic [DEPTH-1:0]          busy
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Clears are applied before the claim so a same-cycle claim wins.
    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NWRITE; p++) begin
            if (wen[p]) begin
                busy_d[wsel[p]] = 1'b0;
            end
        end
        if (claim_en) begin
            busy_d[claim_sel] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with hard-wired zero register and busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data onto the read ports.
module register_file_mp
    import cpu_types_pkg::*;
#(
    parameter int DWIDTH = DEFAULT_DWIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NWRITE-1:0]             wen,
    input  logic [NWRITE-1:0][AW-1:0]     wsel,
    input  logic [NWRITE-1:0][DWIDTH-1:0] wdat,
    input  logic [NREAD-1:0][AW-1:0]      rsel,
    output logic [NREAD-1:0][DWIDTH-1:0]  rdat,
    input  logic                          claim_en,
    input  logic [AW-1:0]                 claim_sel,
    output logic [DEPTH-1:0]              busy,
    output logic [NREAD-1:0]              rbusy
);

    logic [DWIDTH-1:0] regs_q [DEPTH];
    logic [DWIDTH-1:0] regs_d [DEPTH];

    // Ascending port order lets the higher-indexed port win a same-address collision.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < NWRITE; p++) begin
            if (wen[p] && (wsel[p] != '0)) begin
                regs_d[wsel[p]] = wdat[p];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    rf_scoreboard #(
        .DEPTH  (DEPTH),
        .NWRITE (NWRITE)
    ) u_scoreboard (
        .CLK       (CLK),
        .RST       (RST),
        .wen       (wen),
        .wsel      (wsel),
        .claim_en  (claim_en),
        .claim_sel (claim_sel),
        .busy      (busy)
    );

    always_comb begin
        rdat  = '0;
        rbusy = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (rsel[i] != '0) begin
                rdat[i]  = regs_q[rsel[i]];
                rbusy[i] = busy[rsel[i]];
            end
`ifdef RF_BYPASS_EN
            // A forwarded value is no longer pending unless it is being re-claimed now.
            for (int p = 0; p < NWRITE; p++) begin
                if (wen[p] && (wsel[p] != '0) && (wsel[p] == rsel[i])) begin
                    rdat[i]  = wdat[p];
                    rbusy[i] = claim_en && (claim_sel == rsel[i]);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: stimulus queues expectations, a negedge monitor checks them.
module tb_register_file_mp;
    import cpu_types_pkg::*;

    localparam int DW = DEFAULT_DWIDTH;
    localparam int DP = DEFAULT_DEPTH;
    localparam int NR = 2;
    localparam int NW = 2;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef enum int {CHK_RDAT, CHK_RBUSY, CHK_BUSY} chkKind_t;
    typedef struct {
        int       cyc;
        chkKind_t kind;
        int       idx;
        word_t    exp;
        string    name;
    } expect_t;

    expect_t expQ[$];
    int cycleCount = 0;
    int checkCount = 0;
    int errorCount = 0;

    register_file_mp_if #(.DWIDTH(DW), .DEPTH(DP), .NREAD(NR), .NWRITE(NW)) rfIf ();

    register_file_mp #(
        .DWIDTH (DW),
        .DEPTH  (DP),
        .NREAD  (NR),
        .NWRITE (NW)
    ) dut (
        .CLK       (rfIf.CLK),
        .RST       (rfIf.RST),
        .wen       (rfIf.wen),
        .wsel      (rfIf.wsel),
        .wdat      (rfIf.wdat),
        .rsel      (rfIf.rsel),
        .rdat      (rfIf.rdat),
        .claim_en  (rfIf.claim_en),
        .claim_sel (rfIf.claim_sel),
        .busy      (rfIf.busy),
        .rbusy     (rfIf.rbusy)
    );

    initial rfIf.CLK = 1'b0;
    always #5 rfIf.CLK = ~rfIf.CLK;

    always @(posedge rfIf.CLK) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input expect_t e);
        word_t act;
        case (e.kind)
            CHK_RDAT:  act = rfIf.rdat[e.idx];
            CHK_RBUSY: act = word_t'(rfIf.rbusy[e.idx]);
            default:   act = rfIf.busy;
        endcase
        checkCount++;
        if (act !== e.exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
        end
    endtask

    // Monitor: everything queued for the current cycle is compared on the falling edge.
    always @(negedge rfIf.CLK) begin
        expect_t e;
        while (expQ.size() > 0 && expQ[0].cyc <= cycleCount) begin
            e = expQ.pop_front();
            checkOutput(e);
        end
    end

    task automatic expectOutput(input chkKind_t kind, input int idx, input word_t exp, input string name);
        expect_t e;
        e.cyc  = cycleCount;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = exp;
        e.name = name;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus();
        @(posedge rfIf.CLK);
        #1;
        rfIf.RST       = 1'b0;
        rfIf.wen       = '0;
        rfIf.wsel      = '0;
        rfIf.wdat      = '0;
        rfIf.rsel      = '0;
        rfIf.claim_en  = 1'b0;
        rfIf.claim_sel = '0;
    endtask

    initial begin
        rfIf.RST       = 1'b1;
        rfIf.wen       = '0;
        rfIf.wsel      = '0;
        rfIf.wdat      = '0;
        rfIf.rsel      = '0;
        rfIf.claim_en  = 1'b0;
        rfIf.claim_sel = '0;

        // Reset held across one edge, then every address reads zero and idle.
        applyStimulus();
        expectOutput(CHK_BUSY, 0, 32'h0, "reset_busy");
        for (int a = 0; a < DP; a += 2) begin
            if (a > 0) applyStimulus();
            rfIf.rsel[0] = 5'(a);
            rfIf.rsel[1] = 5'(a + 1);
            expectOutput(CHK_RDAT, 0, 32'h0, $sformatf("reset_rdat_r%0d", a));
            expectOutput(CHK_RDAT, 1, 32'h0, $sformatf("reset_rdat_r%0d", a + 1));
            expectOutput(CHK_RBUSY, 0, 32'h0, $sformatf("reset_rbusy_r%0d", a));
            expectOutput(CHK_RBUSY, 1, 32'h0, $sformatf("reset_rbusy_r%0d", a + 1));
        end

        applyStimulus();
        rfIf.wen = 2'b11;
        rfIf.wsel[0] = 5'd5; rfIf.wdat[0] = 32'hAAAA0000;
        rfIf.wsel[1] = 5'd5; rfIf.wdat[1] = 32'h0000BBBB;
        rfIf.rsel[0] = 5'd5; rfIf.rsel[1] = 5'd5;
        expectOutput(CHK_RDAT, 0, BYP ? 32'h0000BBBB : 32'h0, "dual_write_same_cycle_p0");
        expectOutput(CHK_RDAT, 1, BYP ? 32'h0000BBBB : 32'h0, "dual_write_same_cycle_p1");
        applyStimulus();
        rfIf.rsel[0] = 5'd5;
        expectOutput(CHK_RDAT, 0, 32'h0000BBBB, "dual_write_next_cycle");

        applyStimulus();
        rfIf.wen[0] = 1'b1; rfIf.wsel[0] = 5'd0; rfIf.wdat[0] = 32'hDEADBEEF;
        rfIf.claim_en = 1'b1; rfIf.claim_sel = 5'd0;
        rfIf.rsel[1] = 5'd0;
        expectOutput(CHK_RDAT, 1, 32'h0, "zero_write_same_cycle");
        expectOutput(CHK_RBUSY, 1, 32'h0, "zero_claim_same_cycle");
        applyStimulus();
        rfIf.rsel[0] = 5'd0;
        expectOutput(CHK_RDAT, 0, 32'h0, "zero_write_after");
        expectOutput(CHK_BUSY, 0, 32'h0, "zero_claim_busy");

        applyStimulus();
        rfIf.claim_en = 1'b1; rfIf.claim_sel = 5'd7; rfIf.rsel[0] = 5'd7;
        expectOutput(CHK_RBUSY, 0, 32'h0, "claim_r7_not_yet");
        applyStimulus();
        rfIf.wen[0] = 1'b1; rfIf.wsel[0] = 5'd7; rfIf.wdat[0] = 32'h12;
        rfIf.claim_en = 1'b1; rfIf.claim_sel = 5'd7; rfIf.rsel[0] = 5'd7;
        expectOutput(CHK_RBUSY, 0, 32'h1, "claim_r7_pending");
        expectOutput(CHK_RDAT, 0, BYP ? 32'h12 : 32'h0, "claim_write_r7_same_cycle");
        applyStimulus();
        rfIf.rsel[0] = 5'd7;
        expectOutput(CHK_BUSY, 0, 32'h00000080, "claim_wins_busy");
        expectOutput(CHK_RBUSY, 0, 32'h1, "claim_wins_rbusy");
        expectOutput(CHK_RDAT, 0, 32'h12, "claim_write_r7_data");
        applyStimulus();
        rfIf.wen[1] = 1'b1; rfIf.wsel[1] = 5'd7; rfIf.wdat[1] = 32'h34; rfIf.rsel[0] = 5'd7;
        expectOutput(CHK_RBUSY, 0, BYP ? 32'h0 : 32'h1, "write_r7_rbusy_same_cycle");
        expectOutput(CHK_RDAT, 0, BYP ? 32'h34 : 32'h12, "write_r7_rdat_same_cycle");
        applyStimulus();
        rfIf.rsel[0] = 5'd7;
        expectOutput(CHK_BUSY, 0, 32'h0, "write_clears_busy");
        expectOutput(CHK_RDAT, 0, 32'h34, "write_r7_second");

        applyStimulus();
        rfIf.wen[0] = 1'b1; rfIf.wsel[0] = 5'd3; rfIf.wdat[0] = 32'h55; rfIf.rsel[0] = 5'd3;
        expectOutput(CHK_RDAT, 0, BYP ? 32'h55 : 32'h0, "bypass_same_cycle");
        applyStimulus();
        rfIf.rsel[0] = 5'd3;
        expectOutput(CHK_RDAT, 0, 32'h55, "bypass_next_cycle");

        applyStimulus();
        rfIf.claim_en = 1'b1; rfIf.claim_sel = 5'd10;
        applyStimulus();
        expectOutput(CHK_BUSY, 0, 32'h00000400, "claim_r10_busy");
        rfIf.RST = 1'b1;
        rfIf.wen[0] = 1'b1; rfIf.wsel[0] = 5'd9; rfIf.wdat[0] = 32'h77;
        rfIf.claim_en = 1'b1; rfIf.claim_sel = 5'd9;
        rfIf.rsel[1] = 5'd5;
        expectOutput(CHK_RDAT, 1, 32'h0000BBBB, "pre_reset_r5");
        applyStimulus();
        rfIf.rsel[0] = 5'd9; rfIf.rsel[1] = 5'd5;
        expectOutput(CHK_RDAT, 0, 32'h0, "mid_reset_r9");
        expectOutput(CHK_RBUSY, 0, 32'h0, "mid_reset_rbusy_r9");
        expectOutput(CHK_RDAT, 1, 32'h0, "mid_reset_r5");
        expectOutput(CHK_BUSY, 0, 32'h0, "mid_reset_busy");

        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge rfIf.CLK);
        if (expQ.size() > 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
